abs_share_arbiter: RTL and testbench

- Shares one combinational two's-complement absolute-value unit (the existing abs_value datapath, N-bit) between NREQ requesters.
- Round-robin arbitration on a valid/ready request side; single registered result port with requester ID and overflow flag.
- Sits between the operand producers in the CA2 datapath and the downstream consumer of magnitudes.

---
 rtl/abs_arb_pkg.sv | 22 ++
 rtl/abs_value.sv | 11 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/abs_share_arbiter.sv | 110 +++++++++++
 tb/tb_abs_share_arbiter.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/abs_arb_pkg.sv
// Shared definitions for the absolute-value sharing arbiter: state encoding,
// ID-width helper and the most-negative operand pattern.
package abs_arb_pkg;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Only the low n bits are meaningful: 1 followed by n-1 zeros.
  function automatic logic [31:0] most_neg(input int n);
    return 32'd1 << (n - 1);
  endfunction

endpackage

// File: rtl/abs_value.sv
// Combinational two's-complement absolute value; -2^(N-1) wraps to itself.
module abs_value #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  output logic [N-1:0] y
);

  assign y = (a ^ {N{a[N-1]}}) + N'(a[N-1]);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter
  import abs_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  logic [IDW-1:0] cand [NREQ];
  logic           found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand[k] = IDW'((int'(ptr) + k) % NREQ);
    end
    for (int k = 0; k < NREQ; k++) begin
      if (en && !found && req[cand[k]]) begin
        grant[cand[k]] = 1'b1;
        grant_idx      = cand[k];
        found          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/abs_share_arbiter.sv
// Shares one abs_value datapath between NREQ valid/ready requesters with a
// single registered result port (id, overflow flag, transfer counter).
module abs_share_arbiter
  import abs_arb_pkg::*;
#(
  parameter  int N    = 5,
  parameter  int NREQ = 4,
  localparam int IDW  = clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [N-1:0]      resp_data,
  output logic [IDW-1:0]    resp_id,
  output logic              resp_ovf,
  output logic [7:0]        busy_cnt
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; ready never waits on another requester's ready.
  localparam logic [N-1:0] MOST_NEG = N'(most_neg(N));

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic           resp_valid_q, resp_valid_d;
  logic [N-1:0]   resp_data_q, resp_data_d;
  logic [IDW-1:0] resp_id_q, resp_id_d;
  logic           resp_ovf_q, resp_ovf_d;
  logic [7:0]     busy_cnt_q, busy_cnt_d;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic [N-1:0]    operand;
  logic [N-1:0]    abs_res;
  logic            consume;
  logic            can_load;

  assign consume  = resp_valid_q && resp_ready;
  assign can_load = (state_q == S_EMPTY) || consume;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .en        (can_load),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign operand = req_data[int'(grant_idx)*N +: N];

  abs_value #(.N(N)) u_abs (
    .a (operand),
    .y (abs_res)
  );

  // Registers are already held in reset; only the combinational grant needs masking.
  assign req_ready = grant & {NREQ{!rst}};

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    resp_ovf_d   = resp_ovf_q;
    busy_cnt_d   = busy_cnt_q + 8'(consume);
    if (|grant) begin
      state_d      = S_FULL;
      resp_valid_d = 1'b1;
      resp_data_d  = abs_res;
      resp_id_d    = grant_idx;
      resp_ovf_d   = (operand == MOST_NEG);
      rr_ptr_d     = IDW'((int'(grant_idx) + 1) % NREQ);
    end else if (consume) begin
      state_d      = S_EMPTY;
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_EMPTY;
      rr_ptr_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
      resp_ovf_q   <= 1'b0;
      busy_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
      resp_ovf_q   <= resp_ovf_d;
      busy_cnt_q   <= busy_cnt_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;
  assign resp_ovf   = resp_ovf_q;
  assign busy_cnt   = busy_cnt_q;

endmodule

// File: tb/tb_abs_share_arbiter.sv
// Bench for abs_share_arbiter: directed vector table, hand sequences for
// backpressure / async reset / counter wrap, and random traffic vs a model.
module tb_abs_share_arbiter;

  localparam int N    = 5;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int W    = IDW + 1 + N;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*N-1:0] req_data  = '0;
  logic [NREQ-1:0]   req_ready;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [N-1:0]      resp_data;
  logic [IDW-1:0]    resp_id;
  logic              resp_ovf;
  logic [7:0]        busy_cnt;

  abs_share_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_ovf   (resp_ovf),
    .busy_cnt   (busy_cnt)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int             m_ptr;
  bit             m_full;
  logic [N-1:0]   m_data;
  int             m_id;
  bit             m_ovf;
  int             m_cnt;
  logic [W-1:0]   exp_q[$];

  function automatic int signed_val(input logic [N-1:0] a);
    int v;
    v = int'(a);
    if (a[N-1]) v = v - (1 << N);
    return v;
  endfunction

  function automatic logic [N-1:0] ref_abs(input logic [N-1:0] a);
    int v;
    v = signed_val(a);
    if (v < 0) v = -v;
    return v[N-1:0];
  endfunction

  function automatic bit ref_ovf(input logic [N-1:0] a);
    return signed_val(a) == -(1 << (N - 1));
  endfunction

  function automatic int model_grant(input logic [NREQ-1:0] v, input logic rdy);
    if (m_full && !rdy) return -1;
    for (int k = 0; k < NREQ; k++)
      if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_full = 0; m_data = '0; m_id = 0; m_ovf = 0; m_cnt = 0;
    exp_q.delete();
  endtask

  function automatic logic [NREQ*N-1:0] pack4(input logic [N-1:0] d0, d1, d2, d3);
    return {d3, d2, d1, d0};
  endfunction

  // ---------------- driver ----------------
  // Called at posedge+1; drives, checks at posedge+2, advances one edge.
  task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*N-1:0] d,
                      input logic rdy, output logic [NREQ-1:0] rr_seen);
    int g;
    logic [NREQ-1:0] one;
    logic [N-1:0] op;
    logic [W-1:0] e;
    one = 1;
    req_valid = v; req_data = d; resp_ready = rdy;
    #1;
    g = model_grant(v, rdy);
    rr_seen = req_ready;
    chk("req_ready", 32'(req_ready), (g >= 0) ? 32'(one << g) : 32'd0);
    chk("resp_valid", 32'(resp_valid), 32'(m_full));
    chk("resp_data", 32'(resp_data), 32'(m_data));
    chk("resp_id", 32'(resp_id), 32'(m_id));
    chk("resp_ovf", 32'(resp_ovf), 32'(m_ovf));
    chk("busy_cnt", 32'(busy_cnt), 32'(m_cnt));
    if (m_full && rdy) begin
      if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("sb_result", 32'({resp_id, resp_ovf, resp_data}), 32'(e));
      end
    end
    @(posedge clk);
    if (m_full && rdy) begin
      m_cnt  = (m_cnt + 1) % 256;
      m_full = 0;
    end
    if (g >= 0) begin
      op     = d[g*N +: N];
      m_full = 1;
      m_data = ref_abs(op);
      m_id   = g;
      m_ovf  = ref_ovf(op);
      m_ptr  = (g + 1) % NREQ;
      exp_q.push_back({IDW'(g), m_ovf, m_data});
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '1; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_busy_cnt", 32'(busy_cnt), 32'd0);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- directed table ----------------
  typedef struct packed {
    logic [NREQ-1:0]   v;
    logic [NREQ*N-1:0] d;
    logic              rdy;
    logic [NREQ-1:0]   e_rr;
    logic              e_val;
    logic [N-1:0]      e_data;
    logic [IDW-1:0]    e_id;
    logic              e_ovf;
    logic [7:0]        e_cnt;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic [NREQ*N-1:0] d6;
    logic [NREQ-1:0]   rr;
    model_reset();
    d6 = pack4(5'b00001, 5'b11111, 5'b00111, 5'b11000);
    tbl[0]  = '{4'b0010, pack4(5'd0, 5'b11101, 5'd0, 5'd0), 1'b1, 4'b0010, 1'b1, 5'b00011, 2'd1, 1'b0, 8'd0};
    tbl[1]  = '{4'b1000, pack4(5'd0, 5'd0, 5'd0, 5'b10000),  1'b1, 4'b1000, 1'b1, 5'b10000, 2'd3, 1'b1, 8'd1};
    tbl[2]  = '{4'b0001, pack4(5'b00000, 5'd3, 5'd0, 5'd0),  1'b1, 4'b0001, 1'b1, 5'b00000, 2'd0, 1'b0, 8'd2};
    tbl[3]  = '{4'b0100, pack4(5'd0, 5'd0, 5'b01111, 5'd0),  1'b1, 4'b0100, 1'b1, 5'b01111, 2'd2, 1'b0, 8'd3};
    tbl[4]  = '{4'b0000, '0,                                 1'b1, 4'b0000, 1'b0, 5'b01111, 2'd2, 1'b0, 8'd4};
    tbl[5]  = '{4'b1111, d6, 1'b1, 4'b1000, 1'b1, 5'b01000, 2'd3, 1'b0, 8'd4};
    tbl[6]  = '{4'b1111, d6, 1'b1, 4'b0001, 1'b1, 5'b00001, 2'd0, 1'b0, 8'd5};
    tbl[7]  = '{4'b1111, d6, 1'b1, 4'b0010, 1'b1, 5'b00001, 2'd1, 1'b0, 8'd6};
    tbl[8]  = '{4'b1111, d6, 1'b1, 4'b0100, 1'b1, 5'b00111, 2'd2, 1'b0, 8'd7};
    tbl[9]  = '{4'b1111, d6, 1'b1, 4'b1000, 1'b1, 5'b01000, 2'd3, 1'b0, 8'd8};
    tbl[10] = '{4'b0000, '0, 1'b1, 4'b0000, 1'b0, 5'b01000, 2'd3, 1'b0, 8'd9};

    do_reset();

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].rdy, rr);
      chk($sformatf("tbl%0d_rr", i), 32'(rr), 32'(tbl[i].e_rr));
      chk($sformatf("tbl%0d_val", i), 32'(resp_valid), 32'(tbl[i].e_val));
      chk($sformatf("tbl%0d_data", i), 32'(resp_data), 32'(tbl[i].e_data));
      chk($sformatf("tbl%0d_id", i), 32'(resp_id), 32'(tbl[i].e_id));
      chk($sformatf("tbl%0d_ovf", i), 32'(resp_ovf), 32'(tbl[i].e_ovf));
      chk($sformatf("tbl%0d_cnt", i), 32'(busy_cnt), 32'(tbl[i].e_cnt));
    end

    // Backpressure: hold 01001 for three cycles, then consume+load together.
    step(4'b0001, pack4(5'b01001, 5'd0, 5'd0, 5'd0), 1'b0, rr);
    chk("bp_load_rr", 32'(rr), 32'b0001);
    for (int i = 0; i < 3; i++) begin
      step(4'b1111, d6, 1'b0, rr);
      chk("bp_hold_rr", 32'(rr), 32'd0);
      chk("bp_hold_data", 32'(resp_data), 32'b01001);
      chk("bp_hold_id", 32'(resp_id), 32'd0);
      chk("bp_hold_val", 32'(resp_valid), 32'd1);
    end
    step(4'b0100, pack4(5'd0, 5'd0, 5'b10110, 5'd0), 1'b1, rr);
    chk("b2b_rr", 32'(rr), 32'b0100);
    chk("b2b_val", 32'(resp_valid), 32'd1);
    chk("b2b_data", 32'(resp_data), 32'b01010);
    chk("b2b_id", 32'(resp_id), 32'd2);

    // Asynchronous reset while FULL and stalled: outputs clear before any edge.
    req_valid = 4'b1111; resp_ready = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("arst_val", 32'(resp_valid), 32'd0);
    chk("arst_data", 32'(resp_data), 32'd0);
    chk("arst_id", 32'(resp_id), 32'd0);
    chk("arst_ovf", 32'(resp_ovf), 32'd0);
    chk("arst_cnt", 32'(busy_cnt), 32'd0);
    chk("arst_rr", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step(4'b1111, d6, 1'b1, rr);
    chk("post_rst_rr", 32'(rr), 32'b0001);
    chk("post_rst_id", 32'(resp_id), 32'd0);

    // Counter wrap: 256 transfers bring busy_cnt back to 0.
    do_reset();
    for (int i = 0; i < 257; i++) begin
      step(4'b1111, NREQ*N'($urandom), 1'b1, rr);
      if (i == 255) chk("cnt_255", 32'(busy_cnt), 32'd255);
    end
    chk("cnt_wrap", 32'(busy_cnt), 32'd0);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(NREQ'($urandom_range(0, 15)), NREQ*N'($urandom),
           ($urandom_range(0, 3) != 0), rr);
    end
    step('0, '0, 1'b1, rr);
    step('0, '0, 1'b1, rr);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
